ysyx_22050598_mem_arbiter: RTL and testbench

//  Shares the single core memory port between IFU (read-only) and LSU (read/write).
//  One transaction in flight. Fixed LSU priority with a bounded IFU-starvation counter.

---
 rtl/ysyx_22050598_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_22050598_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050598_mem_arbiter.sv
// ysyx_22050598_mem_arbiter: shares the single core memory port between
// the IFU (fetch, read-only) and the LSU (load/store), one transaction at
// a time, LSU-first with a bounded IFU starvation counter and IFU flush.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ifu_req_* / ifu_rsp_* / ifu_flush  fetch request/response, kill
//   lsu_req_* / lsu_rsp_*              load/store request/response
//   mem_req_* / mem_rsp_*              towards the bus bridge
//   busy                               a transaction is in progress
module ysyx_22050598_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifu_req_valid,
    input  logic [AW-1:0]   ifu_req_addr,
    output logic            ifu_req_ready,
    output logic            ifu_rsp_valid,
    output logic [DW-1:0]   ifu_rsp_data,
    input  logic            ifu_flush,
    input  logic            lsu_req_valid,
    input  logic            lsu_req_wen,
    input  logic [AW-1:0]   lsu_req_addr,
    input  logic [DW-1:0]   lsu_req_wdata,
    input  logic [DW/8-1:0] lsu_req_wmask,
    output logic            lsu_req_ready,
    output logic            lsu_rsp_valid,
    output logic [DW-1:0]   lsu_rsp_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_wen,
    output logic [AW-1:0]   mem_req_addr,
    output logic [DW-1:0]   mem_req_wdata,
    output logic [DW/8-1:0] mem_req_wmask,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rsp_data,
    output logic            busy
);

    localparam int MW = DW / 8;
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            drop_q, drop_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            valid_q, valid_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]   wmask_q, wmask_d;

    logic            idle;
    logic            at_max;
    logic            ifu_win;
    logic            lsu_win;
    logic            rsp_fire;
    logic            ifu_kill;

    always_comb begin
        idle     = (state_q == IDLE);
        at_max   = (starve_q == CW'(STARVE_MAX));
        ifu_win  = idle & ifu_req_valid & ~ifu_flush
                 & (~lsu_req_valid | at_max);
        lsu_win  = idle & lsu_req_valid & ~ifu_win;
        rsp_fire = (state_q == WAIT) & mem_rsp_valid;
        // A flush only matters while a fetch owns the port.
        ifu_kill = ~idle & (owner_q == OWN_IFU) & ifu_flush;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        drop_d   = drop_q;
        starve_d = starve_q;
        valid_d  = valid_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        unique case (state_q)
            IDLE: begin
                if (ifu_win) begin
                    state_d  = REQ;
                    owner_d  = OWN_IFU;
                    valid_d  = 1'b1;
                    wen_d    = 1'b0;
                    addr_d   = ifu_req_addr;
                    wdata_d  = '0;
                    wmask_d  = '0;
                    starve_d = '0;
                end else if (lsu_win) begin
                    state_d = REQ;
                    owner_d = OWN_LSU;
                    valid_d = 1'b1;
                    wen_d   = lsu_req_wen;
                    addr_d  = lsu_req_addr;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                    if (!ifu_req_valid)
                        starve_d = '0;
                    else if (!at_max)
                        starve_d = starve_q + CW'(1);
                end
            end
            REQ: begin
                if (ifu_kill)
                    drop_d = 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                    valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (ifu_kill)
                    drop_d = 1'b1;
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IFU;
            drop_q   <= 1'b0;
            starve_q <= '0;
            valid_q  <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
            valid_q  <= valid_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
        end
    end

    always_comb begin
        // Grants are combinational in IDLE; hold them off while in reset.
        ifu_req_ready = rst_n & ifu_win;
        lsu_req_ready = rst_n & lsu_win;
        // A flush in the response cycle itself must also kill the data.
        ifu_rsp_valid = rsp_fire & (owner_q == OWN_IFU)
                      & ~drop_q & ~ifu_flush;
        lsu_rsp_valid = rsp_fire & (owner_q == OWN_LSU);
        ifu_rsp_data  = mem_rsp_data;
        lsu_rsp_data  = mem_rsp_data;
        mem_req_valid = valid_q;
        mem_req_wen   = wen_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        mem_req_wmask = wmask_q;
        busy          = ~idle;
    end

endmodule

// File: tb/tb_ysyx_22050598_mem_arbiter.sv
// tb_ysyx_22050598_mem_arbiter: directed vectors for the memory arbiter,
// table rows plus hand-written store-stall and reset sequences.
module tb_ysyx_22050598_mem_arbiter;

    localparam logic [31:0] IA = 32'h8000_0000;
    localparam logic [31:0] LA = 32'h8000_0010;
    localparam logic [63:0] RD = 64'hDEAD_BEEF;
    localparam logic [63:0] WD = 64'h1122;
    localparam logic [7:0]  WM = 8'h0F;

    // expected flag order: {ifu_rdy, lsu_rdy, mem_vld, ifu_rsp, lsu_rsp, busy}
    localparam logic [5:0] E_IR  = 6'b100000;
    localparam logic [5:0] E_LR  = 6'b010000;
    localparam logic [5:0] E_MV  = 6'b001000;
    localparam logic [5:0] E_IRV = 6'b000100;
    localparam logic [5:0] E_LRV = 6'b000010;
    localparam logic [5:0] E_BZ  = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [63:0] ifu_rsp_data;
    logic        ifu_flush;
    logic        lsu_req_valid;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [63:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        iv;
        logic        fl;
        logic        lv;
        logic        wen;
        logic        mrdy;
        logic        mrsp;
        logic [5:0]  e;
        logic [31:0] ea;
        logic        ew;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    ysyx_22050598_mem_arbiter #(
        .AW(32), .DW(64), .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_addr(ifu_req_addr),
        .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_data(ifu_rsp_data),
        .ifu_flush(ifu_flush),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_wen(lsu_req_wen),
        .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata),
        .lsu_req_wmask(lsu_req_wmask),
        .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    function automatic logic [5:0] flags();
        return {ifu_req_ready, lsu_req_ready, mem_req_valid,
                ifu_rsp_valid, lsu_rsp_valid, busy};
    endfunction

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
        end
    endtask

    function automatic void add(input logic iv, fl, lv, wen, mrdy, mrsp,
                                input logic [5:0] e,
                                input logic [31:0] ea, input logic ew);
        vec_t v;
        v.iv = iv; v.fl = fl; v.lv = lv; v.wen = wen;
        v.mrdy = mrdy; v.mrsp = mrsp; v.e = e; v.ea = ea; v.ew = ew;
        vq.push_back(v);
    endfunction

    task automatic drive(input logic iv, fl, lv, wen, mrdy, mrsp);
        ifu_req_valid = iv;
        ifu_flush     = fl;
        lsu_req_valid = lv;
        lsu_req_wen   = wen;
        mem_req_ready = mrdy;
        mem_rsp_valid = mrsp;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // IFU single read
        add(0,0,0,0,0,0, 6'b0,        0,  0);
        add(1,0,0,0,0,0, E_IR,        0,  0);
        add(0,0,0,0,1,0, E_MV|E_BZ,   IA, 0);
        add(0,0,0,0,0,1, E_IRV|E_BZ,  0,  0);
        add(0,0,0,0,0,0, 6'b0,        0,  0);
        // both requesting: LSU x4 then IFU, twice
        for (int k = 0; k < 10; k++) begin
            logic lw;
            lw = ((k % 5) != 4);
            add(1,0,1,0,0,0, lw ? E_LR : E_IR,           0, 0);
            add(1,0,1,0,1,0, E_MV|E_BZ, lw ? LA : IA,       0);
            add(1,0,1,0,0,1, (lw ? E_LRV : E_IRV)|E_BZ,  0, 0);
        end
        add(0,0,0,0,0,0, 6'b0,        0,  0);
        // flush in WAIT, then a normal fetch
        add(1,0,0,0,0,0, E_IR,        0,  0);
        add(0,0,0,0,1,0, E_MV|E_BZ,   IA, 0);
        add(0,1,0,0,0,0, E_BZ,        0,  0);
        add(0,0,0,0,0,1, E_BZ,        0,  0);
        add(1,0,0,0,0,0, E_IR,        0,  0);
        add(0,0,0,0,1,0, E_MV|E_BZ,   IA, 0);
        add(0,0,0,0,0,1, E_IRV|E_BZ,  0,  0);
        // flush together with the response
        add(1,0,0,0,0,0, E_IR,        0,  0);
        add(0,0,0,0,1,0, E_MV|E_BZ,   IA, 0);
        add(0,1,0,0,0,1, E_BZ,        0,  0);
        add(1,0,0,0,0,0, E_IR,        0,  0);
        add(0,0,0,0,1,0, E_MV|E_BZ,   IA, 0);
        add(0,0,0,0,0,1, E_IRV|E_BZ,  0,  0);
        // flush in REQ: request still held and completed
        add(1,0,0,0,0,0, E_IR,        0,  0);
        add(0,1,0,0,0,0, E_MV|E_BZ,   IA, 0);
        add(0,0,0,0,1,0, E_MV|E_BZ,   IA, 0);
        add(0,0,0,0,0,1, E_BZ,        0,  0);
        // flush in IDLE blocks the grant for that cycle only
        add(1,1,0,0,0,0, 6'b0,        0,  0);
        add(1,0,0,0,0,0, E_IR,        0,  0);
        add(0,0,0,0,1,0, E_MV|E_BZ,   IA, 0);
        add(0,0,0,0,0,1, E_IRV|E_BZ,  0,  0);
        // flush does not touch an LSU transaction
        add(1,1,1,1,0,0, E_LR,        0,  0);
        add(0,1,0,0,1,0, E_MV|E_BZ,   LA, 1);
        add(0,1,0,0,0,1, E_LRV|E_BZ,  0,  0);
        add(0,0,0,0,0,0, 6'b0,        0,  0);

        ifu_req_addr  = IA;
        lsu_req_addr  = LA;
        lsu_req_wdata = WD;
        lsu_req_wmask = WM;
        mem_rsp_data  = RD;
        rst_n = 1'b0;
        drive(1,0,1,0,0,0);
        repeat (2) next_cycle();
        check("reset flags", 128'(flags()), 128'(0));
        check("reset mem fields",
              {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask},
              128'(0));
        drive(0,0,0,0,0,0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].iv, vq[i].fl, vq[i].lv, vq[i].wen,
                  vq[i].mrdy, vq[i].mrsp);
            @(negedge clk);
            check($sformatf("row%0d flags", i), 128'(flags()),
                  128'(vq[i].e));
            if (vq[i].e[3])
                check($sformatf("row%0d wen/addr", i),
                      128'({mem_req_wen, mem_req_addr}),
                      128'({vq[i].ew, vq[i].ea}));
            if (vq[i].e[2])
                check($sformatf("row%0d ifu data", i),
                      128'(ifu_rsp_data), 128'(RD));
            if (vq[i].e[1])
                check($sformatf("row%0d lsu data", i),
                      128'(lsu_rsp_data), 128'(RD));
            next_cycle();
        end

        // store held through three cycles of back-pressure
        drive(0,0,1,1,0,0);
        @(negedge clk);
        check("st grant", 128'(flags()), 128'(E_LR));
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            drive(1,0,0,0,(c == 3),0);
            @(negedge clk);
            check($sformatf("st hold%0d flags", c), 128'(flags()),
                  128'(E_MV|E_BZ));
            check($sformatf("st hold%0d fields", c),
                  {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask},
                  128'({1'b1, LA, WD, WM}));
            next_cycle();
        end
        drive(1,0,0,0,0,0);
        @(negedge clk);
        check("st wait", 128'(flags()), 128'(E_BZ));
        next_cycle();
        drive(1,0,0,0,0,1);
        @(negedge clk);
        check("st rsp", 128'(flags()), 128'(E_LRV|E_BZ));
        next_cycle();
        drive(1,0,0,0,0,0);
        @(negedge clk);
        check("after st ifu grant", 128'(flags()), 128'(E_IR));
        next_cycle();
        drive(0,0,0,0,1,0);
        next_cycle();
        drive(0,0,0,0,0,1);
        next_cycle();
        drive(0,0,0,0,0,0);
        @(negedge clk);
        check("after st idle", 128'(flags()), 128'(0));
        next_cycle();

        // reset in the middle of a request
        drive(1,0,0,0,0,0);
        @(negedge clk);
        check("rst grant", 128'(flags()), 128'(E_IR));
        next_cycle();
        drive(1,0,1,0,0,1);
        @(negedge clk);
        check("rst req", 128'(flags()), 128'(E_MV|E_BZ));
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("rst flags now", 128'(flags()), 128'(0));
        check("rst fields now",
              {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask},
              128'(0));
        @(negedge clk);
        check("rst flags held", 128'(flags()), 128'(0));
        next_cycle();
        rst_n = 1'b1;
        drive(1,0,0,0,0,0);
        @(negedge clk);
        check("post rst grant", 128'(flags()), 128'(E_IR));
        next_cycle();
        drive(0,0,0,0,1,0);
        @(negedge clk);
        check("post rst req",
              128'({flags(), mem_req_addr}),
              128'({E_MV|E_BZ, IA}));
        next_cycle();
        drive(0,0,0,0,0,1);
        @(negedge clk);
        check("post rst rsp", 128'(flags()), 128'(E_IRV|E_BZ));
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
